usb_txn_ctrl: RTL and testbench

Device-side USB transaction controller between the packet receive FSM and the transmit engine. It consumes decoded packets (PID, address, endpoint, CRC status) at packet completion and sequences token, data and handshake phases. It decides the ACK/NAK/STALL response, tracks per-endpoint data toggles, commits or discards received payloads, and releases transmit buffers on acknowledged IN data.

---
 rtl/usb_txn_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: device-side USB transaction sequencer.
// Sits between the rx packet decoder and the tx engine. It accepts tokens,
// picks the ACK/NAK/STALL/DATAx response, and signals commit/discard of OUT
// payloads and release of acknowledged IN payloads.
// Optional feature macro: USB_TXN_TOGGLE_EN enables per-endpoint data toggle
// tracking, duplicate OUT detection and DATA0/DATA1 alternation on IN.
module usb_txn_ctrl #(
  parameter int NUM_ENDP       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                packet_done,
  input  logic [3:0]          rx_pid,
  input  logic [6:0]          rx_addr,
  input  logic [3:0]          rx_endp,
  input  logic                crc_ok,
  input  logic [6:0]          dev_addr,
  input  logic [NUM_ENDP-1:0] ep_stall,
  input  logic                rx_buf_ready,
  input  logic                tx_data_ready,
  input  logic                tx_done,
  output logic                tx_start,
  output logic [3:0]          tx_pid,
  output logic                tx_is_data,
  output logic                rx_commit,
  output logic                rx_discard,
  output logic                tx_buf_release,
  output logic [3:0]          cur_endp,
  output logic                busy
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam int EW = (NUM_ENDP > 1) ? $clog2(NUM_ENDP) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SEND_HS,
    SEND_DATA,
    WAIT_ACK
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          is_setup;

`ifdef USB_TXN_TOGGLE_EN
  logic [NUM_ENDP-1:0] out_tog;
  logic [NUM_ENDP-1:0] in_tog;
`endif

  logic [EW-1:0] rx_idx;
  logic [EW-1:0] cur_idx;
  logic          is_token_pid;
  logic          token_hit;
  logic          is_data_pid;
  logic          timed_out;

  // Endpoint indices are narrowed to the toggle/stall vector width; only
  // endpoints below NUM_ENDP are ever accepted, so the upper bits are zero.
  assign rx_idx       = rx_endp[EW-1:0];
  assign cur_idx      = cur_endp[EW-1:0];
  assign is_token_pid = (rx_pid == PID_OUT) || (rx_pid == PID_IN) || (rx_pid == PID_SETUP);
  assign token_hit    = packet_done && crc_ok && is_token_pid && (rx_addr == dev_addr) &&
                        ({1'b0, rx_endp} < 5'(NUM_ENDP));
  assign is_data_pid  = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
  assign timed_out    = (timer == TIMER_LAST);
  assign busy         = (state != IDLE);

  // Transaction FSM: sequences token/data/handshake phases and drives all
  // registered outputs; pulses default low and are raised for one cycle.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      timer          <= '0;
      is_setup       <= 1'b0;
      cur_endp       <= '0;
      tx_start       <= 1'b0;
      tx_pid         <= '0;
      tx_is_data     <= 1'b0;
      rx_commit      <= 1'b0;
      rx_discard     <= 1'b0;
      tx_buf_release <= 1'b0;
`ifdef USB_TXN_TOGGLE_EN
      out_tog        <= '0;
      in_tog         <= '0;
`endif
    end else begin
      tx_start       <= 1'b0;
      rx_commit      <= 1'b0;
      rx_discard     <= 1'b0;
      tx_buf_release <= 1'b0;

      case (state)
        IDLE: begin
          if (token_hit) begin
            cur_endp <= rx_endp;
            timer    <= '0;
            if (rx_pid == PID_IN) begin
              tx_start <= 1'b1;
              if (ep_stall[rx_idx]) begin
                tx_pid     <= PID_STALL;
                tx_is_data <= 1'b0;
                state      <= SEND_HS;
              end else if (!tx_data_ready) begin
                tx_pid     <= PID_NAK;
                tx_is_data <= 1'b0;
                state      <= SEND_HS;
              end else begin
`ifdef USB_TXN_TOGGLE_EN
                tx_pid     <= in_tog[rx_idx] ? PID_DATA1 : PID_DATA0;
`else
                tx_pid     <= PID_DATA0;
`endif
                tx_is_data <= 1'b1;
                state      <= SEND_DATA;
              end
            end else begin
              is_setup <= (rx_pid == PID_SETUP);
              state    <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (packet_done) begin
            state <= IDLE;
            if (is_data_pid) begin
              if (!crc_ok) begin
                rx_discard <= 1'b1;
              end else begin
                state      <= SEND_HS;
                tx_start   <= 1'b1;
                tx_is_data <= 1'b0;
                if (is_setup) begin
                  tx_pid    <= PID_ACK;
                  rx_commit <= 1'b1;
`ifdef USB_TXN_TOGGLE_EN
                  out_tog[cur_idx] <= 1'b1;
                  in_tog[cur_idx]  <= 1'b1;
`endif
                end else if (ep_stall[cur_idx]) begin
                  tx_pid     <= PID_STALL;
                  rx_discard <= 1'b1;
                end else if (!rx_buf_ready) begin
                  tx_pid     <= PID_NAK;
                  rx_discard <= 1'b1;
`ifdef USB_TXN_TOGGLE_EN
                end else if (rx_pid[3] != out_tog[cur_idx]) begin
                  tx_pid     <= PID_ACK;
                  rx_discard <= 1'b1;
                end else begin
                  tx_pid           <= PID_ACK;
                  rx_commit        <= 1'b1;
                  out_tog[cur_idx] <= ~out_tog[cur_idx];
                end
`else
                end else begin
                  tx_pid    <= PID_ACK;
                  rx_commit <= 1'b1;
                end
`endif
              end
            end
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SEND_HS: begin
          if (tx_done && !tx_start) begin
            state <= IDLE;
          end
        end

        SEND_DATA: begin
          if (tx_done && !tx_start) begin
            state <= WAIT_ACK;
            timer <= '0;
          end
        end

        WAIT_ACK: begin
          if (packet_done) begin
            state <= IDLE;
            if ((rx_pid == PID_ACK) && crc_ok) begin
              tx_buf_release <= 1'b1;
`ifdef USB_TXN_TOGGLE_EN
              in_tog[cur_idx] <= ~in_tog[cur_idx];
`endif
            end
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed self-checking bench for usb_txn_ctrl (dev_addr = 5).
// Expected PIDs follow a small toggle model that is active only when
// USB_TXN_TOGGLE_EN is defined for the build.
module tb_usb_txn_ctrl;

  localparam int NUM_ENDP       = 4;
  localparam int TIMEOUT_CYCLES = 256;
`ifdef USB_TXN_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
  localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;
  localparam logic [6:0] MY_ADDR = 7'd5;

  logic                clk = 1'b0;
  logic                nRST = 1'b0;
  logic                packet_done = 1'b0;
  logic [3:0]          rx_pid = '0;
  logic [6:0]          rx_addr = '0;
  logic [3:0]          rx_endp = '0;
  logic                crc_ok = 1'b1;
  logic [6:0]          dev_addr = MY_ADDR;
  logic [NUM_ENDP-1:0] ep_stall = '0;
  logic                rx_buf_ready = 1'b1;
  logic                tx_data_ready = 1'b1;
  logic                tx_done = 1'b0;
  logic                tx_start;
  logic [3:0]          tx_pid;
  logic                tx_is_data;
  logic                rx_commit;
  logic                rx_discard;
  logic                tx_buf_release;
  logic [3:0]          cur_endp;
  logic                busy;

  int total  = 0;
  int passed = 0;
  logic [NUM_ENDP-1:0] in_m  = '0;
  logic [NUM_ENDP-1:0] out_m = '0;
  logic [3:0]          exp_pid;
  logic                dup;

  usb_txn_ctrl #(.NUM_ENDP(NUM_ENDP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .nRST(nRST), .packet_done(packet_done), .rx_pid(rx_pid),
    .rx_addr(rx_addr), .rx_endp(rx_endp), .crc_ok(crc_ok), .dev_addr(dev_addr),
    .ep_stall(ep_stall), .rx_buf_ready(rx_buf_ready), .tx_data_ready(tx_data_ready),
    .tx_done(tx_done), .tx_start(tx_start), .tx_pid(tx_pid), .tx_is_data(tx_is_data),
    .rx_commit(rx_commit), .rx_discard(rx_discard), .tx_buf_release(tx_buf_release),
    .cur_endp(cur_endp), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] data_pid(input logic t);
    return (TOG_EN && t) ? P_D1 : P_D0;
  endfunction

  // Drives a one-cycle packet; returns at the negedge after the decision edge.
  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr,
                          input logic [3:0] endp, input logic crc);
    @(negedge clk);
    packet_done = 1'b1; rx_pid = pid; rx_addr = addr; rx_endp = endp; crc_ok = crc;
    @(negedge clk);
    packet_done = 1'b0; crc_ok = 1'b1;
  endtask

  task automatic pulse_tx_done;
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({tx_start, tx_is_data, rx_commit, rx_discard, tx_buf_release} !== 5'b0)
      $display("[TB] FAIL reset_pulses: got %b want 00000", {tx_start, tx_is_data, rx_commit, rx_discard, tx_buf_release}); else passed++;
    total++; if ({tx_pid, cur_endp} !== 8'h00) $display("[TB] FAIL reset_pid_endp: got %h want 00", {tx_pid, cur_endp}); else passed++;
    nRST = 1'b1;
  endtask

  task automatic test_ignored_tokens;
    send_pkt(P_IN, 7'd6, 4'd1, 1'b1);
    total++; if ({busy, tx_start} !== 2'b00) $display("[TB] FAIL ign_addr: got %b want 00", {busy, tx_start}); else passed++;
    send_pkt(P_IN, MY_ADDR, 4'd4, 1'b1);
    total++; if ({busy, tx_start} !== 2'b00) $display("[TB] FAIL ign_endp: got %b want 00", {busy, tx_start}); else passed++;
    send_pkt(P_OUT, MY_ADDR, 4'd1, 1'b0);
    total++; if (busy !== 1'b0) $display("[TB] FAIL ign_crc: got %b want 0", busy); else passed++;
  endtask

  task automatic test_in_data;
    tx_data_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_pid = data_pid(in_m[1]);
      send_pkt(P_IN, MY_ADDR, 4'd1, 1'b1);
      total++; if (tx_start !== 1'b1) $display("[TB] FAIL in_start%0d: got %b want 1", r, tx_start); else passed++;
      total++; if (tx_pid !== exp_pid) $display("[TB] FAIL in_pid%0d: got %b want %b", r, tx_pid, exp_pid); else passed++;
      total++; if ({tx_is_data, busy, cur_endp} !== 6'b11_0001) $display("[TB] FAIL in_flags%0d: got %b want 110001", r, {tx_is_data, busy, cur_endp}); else passed++;
      pulse_tx_done;
      total++; if ({busy, tx_buf_release} !== 2'b10) $display("[TB] FAIL in_waitack%0d: got %b want 10", r, {busy, tx_buf_release}); else passed++;
      send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
      total++; if (tx_buf_release !== 1'b1) $display("[TB] FAIL in_release%0d: got %b want 1", r, tx_buf_release); else passed++;
      in_m[1] = in_m[1] ^ TOG_EN;
      @(negedge clk);
      total++; if ({busy, tx_buf_release} !== 2'b00) $display("[TB] FAIL in_done%0d: got %b want 00", r, {busy, tx_buf_release}); else passed++;
    end
  endtask

  task automatic test_in_stall_nak;
    ep_stall = 4'b0010;
    send_pkt(P_IN, MY_ADDR, 4'd1, 1'b1);
    tx_done = 1'b1;
    total++; if ({tx_start, tx_is_data, tx_pid} !== {2'b10, P_STALL}) $display("[TB] FAIL stall_resp: got %b want %b", {tx_start, tx_is_data, tx_pid}, {2'b10, P_STALL}); else passed++;
    @(negedge clk); tx_done = 1'b0;
    total++; if (busy !== 1'b1) $display("[TB] FAIL stall_txdone_ignored: got %b want 1", busy); else passed++;
    pulse_tx_done;
    total++; if ({busy, tx_buf_release} !== 2'b00) $display("[TB] FAIL stall_done: got %b want 00", {busy, tx_buf_release}); else passed++;
    ep_stall = '0; tx_data_ready = 1'b0;
    send_pkt(P_IN, MY_ADDR, 4'd1, 1'b1);
    total++; if ({tx_start, tx_is_data, tx_pid} !== {2'b10, P_NAK}) $display("[TB] FAIL nak_resp: got %b want %b", {tx_start, tx_is_data, tx_pid}, {2'b10, P_NAK}); else passed++;
    pulse_tx_done;
    total++; if (busy !== 1'b0) $display("[TB] FAIL nak_done: got %b want 0", busy); else passed++;
    tx_data_ready = 1'b1;
  endtask

  task automatic test_out;
    rx_buf_ready = 1'b1;
    send_pkt(P_OUT, MY_ADDR, 4'd2, 1'b1);
    total++; if ({busy, tx_start} !== 2'b10) $display("[TB] FAIL out_wait: got %b want 10", {busy, tx_start}); else passed++;
    send_pkt(P_D0, 7'd0, 4'd0, 1'b1);
    total++; if ({tx_start, tx_pid, rx_commit, rx_discard} !== {1'b1, P_ACK, 2'b10}) $display("[TB] FAIL out_first: got %b want %b", {tx_start, tx_pid, rx_commit, rx_discard}, {1'b1, P_ACK, 2'b10}); else passed++;
    out_m[2] = out_m[2] ^ TOG_EN;
    pulse_tx_done;
    dup = TOG_EN && (out_m[2] != 1'b0);
    send_pkt(P_OUT, MY_ADDR, 4'd2, 1'b1);
    send_pkt(P_D0, 7'd0, 4'd0, 1'b1);
    total++; if ({tx_pid, rx_commit, rx_discard} !== {P_ACK, !dup, dup}) $display("[TB] FAIL out_resend: got %b want %b", {tx_pid, rx_commit, rx_discard}, {P_ACK, !dup, dup}); else passed++;
    if (!dup) out_m[2] = out_m[2] ^ TOG_EN;
    pulse_tx_done;
    rx_buf_ready = 1'b0;
    send_pkt(P_OUT, MY_ADDR, 4'd2, 1'b1);
    send_pkt(P_D1, 7'd0, 4'd0, 1'b1);
    total++; if ({tx_pid, rx_commit, rx_discard} !== {P_NAK, 2'b01}) $display("[TB] FAIL out_nak: got %b want %b", {tx_pid, rx_commit, rx_discard}, {P_NAK, 2'b01}); else passed++;
    pulse_tx_done;
    rx_buf_ready = 1'b1;
  endtask

  task automatic test_setup;
    ep_stall = 4'b0010; rx_buf_ready = 1'b0;
    send_pkt(P_SETUP, MY_ADDR, 4'd1, 1'b1);
    send_pkt(P_D0, 7'd0, 4'd0, 1'b1);
    total++; if ({tx_start, tx_pid, rx_commit, rx_discard} !== {1'b1, P_ACK, 2'b10}) $display("[TB] FAIL setup_ack: got %b want %b", {tx_start, tx_pid, rx_commit, rx_discard}, {1'b1, P_ACK, 2'b10}); else passed++;
    if (TOG_EN) begin in_m[1] = 1'b1; out_m[1] = 1'b1; end
    pulse_tx_done;
    ep_stall = '0; rx_buf_ready = 1'b1; tx_data_ready = 1'b1;
    exp_pid = data_pid(in_m[1]);
    send_pkt(P_IN, MY_ADDR, 4'd1, 1'b1);
    total++; if (tx_pid !== exp_pid) $display("[TB] FAIL setup_next_in: got %b want %b", tx_pid, exp_pid); else passed++;
    pulse_tx_done;
    send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
    in_m[1] = in_m[1] ^ TOG_EN;
  endtask

  task automatic test_crc_bad_and_nondata;
    send_pkt(P_OUT, MY_ADDR, 4'd2, 1'b1);
    send_pkt(P_D1, 7'd0, 4'd0, 1'b0);
    total++; if ({rx_discard, rx_commit, tx_start, busy} !== 4'b1000) $display("[TB] FAIL crc_bad: got %b want 1000", {rx_discard, rx_commit, tx_start, busy}); else passed++;
    send_pkt(P_OUT, MY_ADDR, 4'd2, 1'b1);
    send_pkt(P_IN, MY_ADDR, 4'd1, 1'b1);
    total++; if ({busy, tx_start, rx_discard} !== 3'b000) $display("[TB] FAIL nondata_abort: got %b want 000", {busy, tx_start, rx_discard}); else passed++;
    @(negedge clk);
    total++; if ({busy, tx_start} !== 2'b00) $display("[TB] FAIL nondata_not_token: got %b want 00", {busy, tx_start}); else passed++;
  endtask

  task automatic test_timeout_and_reset;
    tx_data_ready = 1'b1;
    send_pkt(P_IN, MY_ADDR, 4'd3, 1'b1);
    pulse_tx_done;
    send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
    in_m[3] = in_m[3] ^ TOG_EN;
    exp_pid = data_pid(in_m[3]);
    send_pkt(P_IN, MY_ADDR, 4'd3, 1'b1);
    total++; if (tx_pid !== exp_pid) $display("[TB] FAIL to_first_pid: got %b want %b", tx_pid, exp_pid); else passed++;
    pulse_tx_done;
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    total++; if (busy !== 1'b1) $display("[TB] FAIL to_before: got %b want 1", busy); else passed++;
    @(negedge clk);
    total++; if ({busy, tx_buf_release} !== 2'b00) $display("[TB] FAIL to_expired: got %b want 00", {busy, tx_buf_release}); else passed++;
    send_pkt(P_IN, MY_ADDR, 4'd3, 1'b1);
    total++; if (tx_pid !== exp_pid) $display("[TB] FAIL to_retry_pid: got %b want %b", tx_pid, exp_pid); else passed++;
    pulse_tx_done;
    #2 nRST = 1'b0;
    #1;
    total++; if ({busy, tx_start, tx_is_data, rx_commit, rx_discard, tx_buf_release, tx_pid, cur_endp} !== 14'b0)
      $display("[TB] FAIL rst_mid: got %b want 0", {busy, tx_start, tx_is_data, rx_commit, rx_discard, tx_buf_release, tx_pid, cur_endp}); else passed++;
    in_m = '0; out_m = '0;
    @(negedge clk); nRST = 1'b1;
    send_pkt(P_IN, MY_ADDR, 4'd3, 1'b1);
    total++; if (tx_pid !== P_D0) $display("[TB] FAIL rst_toggle: got %b want %b", tx_pid, P_D0); else passed++;
    pulse_tx_done;
    send_pkt(P_ACK, 7'd0, 4'd0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_ignored_tokens;
    test_in_data;
    test_in_stall_nak;
    test_out;
    test_setup;
    test_crc_bad_and_nondata;
    test_timeout_and_reset;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
